// File: rtl/fixed_unsigned_cast_pipe.sv
// Unsigned fixed-point cast: per-lane align/round (S1), clamp/register (S2),
// valid/ready pipeline with sticky saturation flag and saturating counter.

module fixed_unsigned_cast_lane #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 4,
  parameter int OUT_FRAC_WIDTH = 2,
  parameter int ROUND_MODE     = 0,
  parameter int MID_W          = 9
) (
  input  logic [IN_WIDTH-1:0] din,
  output logic [MID_W-1:0]    mid
);
  localparam int SH_L = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? OUT_FRAC_WIDTH - IN_FRAC_WIDTH : 0;
  localparam int SH_R = (OUT_FRAC_WIDTH <  IN_FRAC_WIDTH) ? IN_FRAC_WIDTH - OUT_FRAC_WIDTH : 0;

  if (SH_R == 0) begin : g_shl
    assign mid = MID_W'(din) << SH_L;
  end else begin : g_rnd
    logic [IN_WIDTH-1:0] q;
    logic [SH_R-1:0]     r, h;
    logic                inc;

    assign q = din >> SH_R;
    assign r = din[SH_R-1:0];
    assign h = SH_R'(1) << (SH_R - 1);

    always_comb begin
      inc = 1'b0;
      case (ROUND_MODE)
        1:       inc = (r >= h);
        2:       inc = (r > h) || ((r == h) && q[0]);
        default: inc = 1'b0;
      endcase
    end

    // MID_W has one spare MSB so the rounding carry cannot wrap
    assign mid = MID_W'(q) + MID_W'(inc);
  end
endmodule

module fixed_unsigned_cast_pipe #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 4,
  parameter int OUT_WIDTH      = 4,
  parameter int OUT_FRAC_WIDTH = 2,
  parameter int PARALLELISM    = 4,
  parameter int ROUND_MODE     = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PARALLELISM*IN_WIDTH-1:0]  data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [PARALLELISM*OUT_WIDTH-1:0] data_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  input  logic                             sat_clear,
  output logic                             sat_flag,
  output logic [CNT_WIDTH-1:0]             sat_count
);
  localparam int SH_L   = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? OUT_FRAC_WIDTH - IN_FRAC_WIDTH : 0;
  localparam int MID_W  = IN_WIDTH + SH_L + 1;
  localparam int STAGES = 2;
  localparam int PC_W   = $clog2(PARALLELISM + 1);
  localparam int SUM_W  = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

  if (IN_FRAC_WIDTH > IN_WIDTH || OUT_FRAC_WIDTH > OUT_WIDTH || PARALLELISM < 1 ||
      ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_param_err
    $error("fixed_unsigned_cast_pipe: illegal parameter combination");
  end

  logic [STAGES:1]                        vld_pipe;
  logic                                   adv1, adv2, out_hs;
  logic [PARALLELISM-1:0][MID_W-1:0]      mid, s1_mid;
  logic [PARALLELISM-1:0][OUT_WIDTH-1:0]  clamp;
  logic [PARALLELISM-1:0]                 clamp_sat, s2_sat;
  logic [PC_W-1:0]                        sat_num;
  logic [SUM_W-1:0]                       sat_sum;

  assign adv2           = !vld_pipe[2] || data_out_ready;
  assign adv1           = !vld_pipe[1] || adv2;
  assign data_in_ready  = adv1;
  assign data_out_valid = vld_pipe[2];
  assign out_hs         = vld_pipe[2] && data_out_ready;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    fixed_unsigned_cast_lane #(
      .IN_WIDTH       (IN_WIDTH),
      .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
      .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
      .ROUND_MODE     (ROUND_MODE),
      .MID_W          (MID_W)
    ) u_lane (
      .din (data_in[i*IN_WIDTH +: IN_WIDTH]),
      .mid (mid[i])
    );

    if (MID_W > OUT_WIDTH) begin : g_clamp
      assign clamp_sat[i] = |s1_mid[i][MID_W-1:OUT_WIDTH];
      assign clamp[i]     = clamp_sat[i] ? {OUT_WIDTH{1'b1}} : s1_mid[i][OUT_WIDTH-1:0];
    end else begin : g_wide
      assign clamp_sat[i] = 1'b0;
      assign clamp[i]     = OUT_WIDTH'(s1_mid[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_mid   <= '0;
      data_out <= '0;
      s2_sat   <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= data_in_valid;
        if (data_in_valid) s1_mid <= mid;
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          data_out <= clamp;
          s2_sat   <= clamp_sat;
        end
      end
    end
  end

  always_comb begin
    sat_num = '0;
    for (int i = 0; i < PARALLELISM; i++) sat_num = sat_num + PC_W'(s2_sat[i]);
  end

  assign sat_sum = SUM_W'(sat_count) + SUM_W'(sat_num);

  // Counted at the output handshake so a stalled transfer is counted once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (out_hs && (|s2_sat)) begin
      sat_flag  <= 1'b1;
      sat_count <= (sat_sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_fixed_unsigned_cast_pipe.sv
// Scoreboard bench: four instances (floor, half-even, half-up, floor with 2-bit counter)
// share one stimulus stream; expectations come from a reference rounding model.

module tb_fixed_unsigned_cast_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_in_valid, data_out_ready, sat_clear;
  logic [3:0]  rdy, dv, flg;
  logic [15:0] dout [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [1:0]  cnt3;

  always #5 clk = ~clk;

  fixed_unsigned_cast_pipe #(.ROUND_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy[0]),
    .data_out(dout[0]), .data_out_valid(dv[0]), .data_out_ready(data_out_ready),
    .sat_clear(sat_clear), .sat_flag(flg[0]), .sat_count(cnt0));
  fixed_unsigned_cast_pipe #(.ROUND_MODE(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy[1]),
    .data_out(dout[1]), .data_out_valid(dv[1]), .data_out_ready(data_out_ready),
    .sat_clear(sat_clear), .sat_flag(flg[1]), .sat_count(cnt1));
  fixed_unsigned_cast_pipe #(.ROUND_MODE(1)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy[2]),
    .data_out(dout[2]), .data_out_valid(dv[2]), .data_out_ready(data_out_ready),
    .sat_clear(sat_clear), .sat_flag(flg[2]), .sat_count(cnt2));
  fixed_unsigned_cast_pipe #(.ROUND_MODE(0), .CNT_WIDTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy[3]),
    .data_out(dout[3]), .data_out_valid(dv[3]), .data_out_ready(data_out_ready),
    .sat_clear(sat_clear), .sat_flag(flg[3]), .sat_count(cnt3));

  typedef struct {
    logic [15:0] e0, e1, e2;
    int          s0, s1, s2;
  } exp_t;

  exp_t        sbq [$];
  int          n_cmp = 0, n_bad = 0;
  int          m_cnt0 = 0, m_cnt1 = 0, m_cnt2 = 0, m_cnt3 = 0;
  logic [3:0]  m_flg = '0;
  logic        held_v = 1'b0;
  logic [15:0] held_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // 8-bit Q4.4 -> 4-bit Q2.2 reference; returns {sat, value}
  function automatic logic [4:0] cast_el(input logic [7:0] x, input int mode);
    int q, r, v;
    q = int'(x) / 4;
    r = int'(x) % 4;
    v = q;
    if (mode == 1 && r >= 2) v = q + 1;
    if (mode == 2 && (r > 2 || (r == 2 && (q % 2) == 1))) v = q + 1;
    if (v > 15) return 5'h1F;
    return {1'b0, v[3:0]};
  endfunction

  function automatic void cast_vec(input logic [31:0] d, input int mode,
                                   output logic [15:0] o, output int ns);
    logic [4:0] e;
    ns = 0;
    for (int i = 0; i < 4; i++) begin
      e = cast_el(d[i*8 +: 8], mode);
      o[i*4 +: 4] = e[3:0];
      ns += int'(e[4]);
    end
  endfunction

  function automatic int sat_add(input int a, input int b, input int cap);
    return (a + b > cap) ? cap : a + b;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0; m_cnt3 = 0; m_flg = '0; held_v = 1'b0;
    end else begin
      chk("in_ready", {28'd0, rdy}, {28'd0, {4{(sbq.size() < 2) || data_out_ready}}});
      chk("sat_count0", {16'd0, cnt0}, m_cnt0);
      chk("sat_count1", {16'd0, cnt1}, m_cnt1);
      chk("sat_count2", {16'd0, cnt2}, m_cnt2);
      chk("sat_count3", {30'd0, cnt3}, m_cnt3);
      chk("sat_flags", {28'd0, flg}, {28'd0, m_flg});
      if (held_v) chk("stall_hold", {16'd0, dout[0]}, {16'd0, held_d});
      held_v = dv[0] && !data_out_ready;
      held_d = dout[0];
      if (dv[0] && data_out_ready) begin
        if (sbq.size() == 0) chk("spurious_out", {16'd0, dout[0]}, 32'hDEAD_BEEF);
        else begin
          e = sbq.pop_front();
          chk("out_valid_all", {28'd0, dv}, 32'hF);
          chk("dout_floor",    {16'd0, dout[0]}, {16'd0, e.e0});
          chk("dout_halfeven", {16'd0, dout[1]}, {16'd0, e.e1});
          chk("dout_halfup",   {16'd0, dout[2]}, {16'd0, e.e2});
          chk("dout_floor_c2", {16'd0, dout[3]}, {16'd0, e.e0});
          if (!sat_clear) begin
            m_cnt0 = sat_add(m_cnt0, e.s0, 65535);
            m_cnt1 = sat_add(m_cnt1, e.s1, 65535);
            m_cnt2 = sat_add(m_cnt2, e.s2, 65535);
            m_cnt3 = sat_add(m_cnt3, e.s0, 3);
            m_flg  = m_flg | {e.s0 > 0, e.s2 > 0, e.s1 > 0, e.s0 > 0};
          end
        end
      end
      if (sat_clear) begin
        m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0; m_cnt3 = 0; m_flg = '0;
      end
      if (data_in_valid && rdy[0]) begin
        cast_vec(data_in, 0, e.e0, e.s0);
        cast_vec(data_in, 2, e.e1, e.s1);
        cast_vec(data_in, 1, e.e2, e.s2);
        sbq.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] d);
    int n = 0;
    data_in       = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!rdy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", n, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b1; sat_clear = 1'b0;
    #12;
    chk("rst_valid", {28'd0, dv}, 0);
    chk("rst_dout", {16'd0, dout[0]}, 0);
    chk("rst_sat", {16'd0, cnt0 | cnt1 | cnt2 | 16'(cnt3)}, 0);
    chk("rst_flag", {28'd0, flg}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Two-cycle latency with floor example vector
    send(32'hF0_1A_16_2B);
    chk("lat_c1", {31'd0, dv[0]}, 0);
    @(posedge clk); #1;
    chk("lat_c2", {31'd0, dv[0]}, 1);
    chk("lat_dout", {16'd0, dout[0]}, 32'h0000_F65A);
    drain();
    chk("floor_sat_count", {16'd0, cnt0}, 1);
    chk("floor_sat_flag", {31'd0, flg[0]}, 1);

    send(32'hFF_1A_16_2B);
    send(32'h12_1A_12_1A);
    send(32'h02_06_0A_0E);
    send(32'h00_FF_3E_3D);
    for (int i = 0; i < 10; i++) send($urandom);
    drain();

    // Backpressure: random ready with a 5-cycle hold at 0
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          #1 data_out_ready = (c >= 6 && c < 11) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        data_out_ready = 1'b1;
      end
    join
    drain();

    // Sticky counter, then clear colliding with a saturating handshake
    @(posedge clk); #1 sat_clear = 1'b1;
    @(posedge clk); #1 sat_clear = 1'b0;
    send(32'hF0_F0_F0_F0);
    send(32'hF0_F0_F0_F0);
    drain();
    chk("cnt2b_sticky", {30'd0, cnt3}, 3);
    chk("cnt16_total", {16'd0, cnt0}, 8);
    data_out_ready = 1'b0;
    send(32'hF0_F0_F0_F0);
    repeat (2) @(posedge clk);
    #1 sat_clear = 1'b1; data_out_ready = 1'b1;
    @(posedge clk); #1 sat_clear = 1'b0;
    chk("clr_hs_count", {30'd0, cnt3}, 0);
    chk("clr_hs_count16", {16'd0, cnt0}, 0);
    chk("clr_hs_flag", {28'd0, flg}, 0);
    chk("clr_hs_empty", {31'd0, dv[0]}, 0);
    drain();

    // Reset with both stages full
    data_out_ready = 1'b0;
    send(32'h11_22_33_44);
    send(32'h55_66_77_88);
    chk("full_ready", {31'd0, rdy[0]}, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {28'd0, dv}, 0);
    chk("async_rst_dout", {16'd0, dout[0]}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; data_out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, rdy[0]}, 1);
    repeat (4) @(posedge clk);
    #1 chk("post_rst_no_old", {28'd0, dv}, 0);
    send(32'h2B_16_1A_F0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
